// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave core.
package spi_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam byte_t LOOPBACK_MASK = 8'h55;
    localparam int DEFAULT_FIFO_DEPTH = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; a pop on a full FIFO frees room for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI mode-0 slave with RX/TX FIFOs, oversampled on MAX10_CLK1_50.
// Define SPI_LOOPBACK_EN to echo every received byte (XOR 0x55) into the TX FIFO.
module spi_slave_core import spi_pkg::*; #(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic  MAX10_CLK1_50,
    input  logic  rst,
    input  logic  SPI_CLK,
    input  logic  SPI_MOSI,
    input  logic  SPI_CS,
    output logic  SPI_MISO,
    output logic  data_valid,
    output byte_t rx_data,
    output logic  rx_valid,
    input  logic  rx_ready,
    input  byte_t tx_data,
    input  logic  tx_valid,
    output logic  tx_ready,
    output logic  rx_overflow
);
    logic [2:0] sck_s, cs_s;
    logic [1:0] mosi_s;
    state_t state, state_nx;
    byte_t rx_shift, tx_shift, tx_head, tx_din;
    logic [2:0] bit_cnt;
    logic rx_pend, dv;
    logic sck_rise, sck_fall, cs_fall, cs_high, active, sample, shift_out, tx_load;
    logic rx_empty, rx_full, rx_pop, tx_empty, tx_full, tx_push, tx_pop, lb_push;

    // Synchronizers reset to 0 so a CS already low at reset release is not seen as a falling edge.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            sck_s <= '0;
            cs_s <= '0;
            mosi_s <= '0;
        end else begin
            sck_s <= {sck_s[1:0], SPI_CLK};
            cs_s <= {cs_s[1:0], SPI_CS};
            mosi_s <= {mosi_s[0], SPI_MOSI};
        end
    end

    assign sck_rise = sck_s[1] && !sck_s[2];
    assign sck_fall = !sck_s[1] && sck_s[2];
    assign cs_fall = !cs_s[1] && cs_s[2];
    assign cs_high = cs_s[1];

    always_ff @(posedge MAX10_CLK1_50)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_high ? IDLE : ACTIVE);
    end

    assign active = state == ACTIVE && !cs_high;
    assign sample = active && sck_rise;
    assign shift_out = active && sck_fall;
    assign tx_load = (state == IDLE && cs_fall) || (shift_out && bit_cnt == 3'd0);
    assign tx_pop = tx_load && !tx_empty;
    assign rx_valid = !rx_empty;
    assign rx_pop = rx_valid && rx_ready;
    assign SPI_MISO = state == ACTIVE && tx_shift[7];
    assign data_valid = state == ACTIVE && dv;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            rx_shift <= '0;
            tx_shift <= '0;
            bit_cnt <= '0;
            rx_pend <= 1'b0;
            dv <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_pend <= sample && bit_cnt == 3'd7;
            if (rx_pend && rx_full && !rx_pop) rx_overflow <= 1'b1;
            if (state == ACTIVE && cs_high) begin
                bit_cnt <= '0;
            end else if (sample) begin
                rx_shift <= {rx_shift[6:0], mosi_s[1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (tx_load) begin
                tx_shift <= tx_empty ? 8'h00 : tx_head;
                dv <= !tx_empty;
            end else if (shift_out) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

`ifdef SPI_LOOPBACK_EN
    assign lb_push = rx_pend && (!rx_full || rx_pop) && !tx_full;
`else
    assign lb_push = 1'b0;
`endif
    assign tx_ready = !tx_full && !lb_push;
    assign tx_push = lb_push || (tx_valid && tx_ready);
    assign tx_din = lb_push ? rx_shift ^ LOOPBACK_MASK : tx_data;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(MAX10_CLK1_50),
        .rst(rst),
        .push(rx_pend),
        .din(rx_shift),
        .pop(rx_pop),
        .dout(rx_data),
        .empty(rx_empty),
        .full(rx_full)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(MAX10_CLK1_50),
        .rst(rst),
        .push(tx_push),
        .din(tx_din),
        .pop(tx_pop),
        .dout(tx_head),
        .empty(tx_empty),
        .full(tx_full)
    );
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed plus random SPI transfers checked against a queue-based model.
module tb_spi_slave_core;
    localparam int DEPTH = 8;
    localparam int H = 8;

    logic clk, rst, sck, mosi, cs, miso, dv, rx_valid, rx_ready, tx_valid, tx_ready, rx_overflow;
    logic [7:0] rx_data, tx_data;

    spi_slave_core #(.FIFO_DEPTH(DEPTH)) dut (
        .MAX10_CLK1_50(clk),
        .rst(rst),
        .SPI_CLK(sck),
        .SPI_MOSI(mosi),
        .SPI_CS(cs),
        .SPI_MISO(miso),
        .data_valid(dv),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_overflow(rx_overflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int errors = 0, checks = 0, lat;
    logic [7:0] rx_q[$], tx_q[$];
    logic ovf_m;
    logic [7:0] exp_tx, last_got;
    logic exp_dv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The slave loads the next MISO byte from TX on CS fall and after every full byte.
    task automatic model_load();
        exp_dv = tx_q.size() > 0;
        exp_tx = exp_dv ? tx_q.pop_front() : 8'h00;
    endtask

    task automatic do_reset();
        rst = 1;
        clks(2);
        rst = 0;
        clks(2);
        rx_q.delete();
        tx_q.delete();
        ovf_m = 0;
    endtask

    task automatic cs_start();
        cs = 0;
        clks(H);
        model_load();
    endtask

    task automatic cs_end();
        clks(H);
        cs = 1;
        clks(H);
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int n, output logic [7:0] got, output logic gdv);
        got = 8'h00;
        gdv = 1'b0;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            clks(H);
            got[i] = miso;
            if (i == 7) gdv = dv;
            sck = 1;
            if (i == 0) begin
                lat = -1;
                for (int k = 1; k <= H; k++) begin
                    clks(1);
                    if (lat < 0 && rx_valid) lat = k;
                end
            end else begin
                clks(H);
            end
            sck = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        logic [7:0] got, e;
        logic gdv, edv;
        e = exp_tx;
        edv = exp_dv;
        xfer_bits(b, 8, got, gdv);
        last_got = got;
        chk({tag, " miso"}, got, e);
        chk({tag, " dv"}, gdv, edv);
        if (rx_q.size() < DEPTH) begin
            rx_q.push_back(b);
`ifdef SPI_LOOPBACK_EN
            if (tx_q.size() < DEPTH) tx_q.push_back(b ^ 8'h55);
`endif
        end else begin
            ovf_m = 1;
        end
        model_load();
    endtask

    task automatic tx_push(input logic [7:0] b);
        chk("tx_ready", tx_ready, tx_q.size() < DEPTH);
        tx_data = b;
        tx_valid = 1;
        clks(1);
        tx_valid = 0;
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
    endtask

    task automatic drain();
        logic [7:0] e;
        while (rx_q.size() > 0) begin
            e = rx_q.pop_front();
            chk("rx_valid", rx_valid, 1);
            chk("rx_data", rx_data, e);
            rx_ready = 1;
            clks(1);
            rx_ready = 0;
        end
        chk("rx_empty", rx_valid, 0);
        chk("rx_overflow", rx_overflow, ovf_m);
    endtask

    initial begin
        logic [7:0] g;
        logic d;
        rst = 1; sck = 0; mosi = 0; cs = 1; rx_ready = 0; tx_valid = 0; tx_data = 0;
        clks(3);
        chk("reset miso", miso, 0);
        chk("reset dv", dv, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset tx_ready", tx_ready, 1);
        chk("reset overflow", rx_overflow, 0);
        do_reset();

        cs_start();
        send_byte(8'hA5, "a5");
        chk("a5 latency", lat >= 1 && lat <= 5, 1);
        chk("a5 data", rx_data, 8'hA5);
        cs_end();
        drain();

        do_reset();
        cs_start();
        for (int i = 1; i <= 9; i++) send_byte(8'(i), "ovf");
        cs_end();
        chk("ovf flag", rx_overflow, 1);
        drain();

        do_reset();
        tx_push(8'h3C);
        cs_start();
        send_byte(8'h99, "tx3c");
        chk("tx3c byte", last_got, 8'h3C);
        send_byte(8'h66, "tx3c next");
        cs_end();
        drain();

        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) tx_push(8'(i + 8'h40));

        do_reset();
        cs_start();
        xfer_bits(8'hB5, 5, g, d);
        clks(H);
        cs = 1;
        clks(H);
        cs_start();
        send_byte(8'h7E, "partial");
        cs_end();
        drain();

`ifdef SPI_LOOPBACK_EN
        do_reset();
        cs_start();
        send_byte(8'h12, "lb0");
        send_byte(8'h00, "lb1");
        chk("loopback byte", last_got, 8'h47);
        cs_end();
        drain();
`endif

        do_reset();
        tx_push(8'hFF);
        cs_start();
        xfer_bits(8'h5A, 3, g, d);
        rst = 1;
        clks(2);
        chk("midrst miso", miso, 0);
        chk("midrst dv", dv, 0);
        chk("midrst rx_valid", rx_valid, 0);
        chk("midrst tx_ready", tx_ready, 1);
        chk("midrst ovf", rx_overflow, 0);
        rx_q.delete();
        tx_q.delete();
        ovf_m = 0;
        rst = 0;
        clks(H);
        chk("post rst idle miso", miso, 0);
        chk("post rst idle dv", dv, 0);
        cs = 1;
        clks(H);
        cs_start();
        send_byte(8'hC3, "c3");
        cs_end();
        drain();

        do_reset();
        for (int it = 0; it < 15; it++) begin
            int np, nb;
            np = $urandom_range(0, 3);
            nb = $urandom_range(1, 3);
            for (int j = 0; j < np; j++) tx_push(8'($urandom));
            cs_start();
            for (int j = 0; j < nb; j++) send_byte(8'($urandom), "rand");
            cs_end();
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
